// File: rtl/sobel_gradient_pipe.sv
// Three-stage Sobel gradient pipeline: partial sums, signed Gx/Gy, then mode
// select (Gx, Gy, |Gx|+|Gy| or thresholded edge) with a saturating edge counter.
module sobel_gradient_pipe #(
  parameter int PIXEL_W = 8,
  parameter int CNT_W   = 16,
  localparam int RW     = PIXEL_W + 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [9*PIXEL_W-1:0] window_in,
  input  logic [1:0]           mode,
  input  logic [RW-1:0]        threshold,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [RW-1:0]        result,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clear_count,
  output logic [CNT_W-1:0]     edge_count
);

  localparam int PW = PIXEL_W + 2;
  localparam logic [1:0] MODE_GX   = 2'b00;
  localparam logic [1:0] MODE_GY   = 2'b01;
  localparam logic [1:0] MODE_MAG  = 2'b10;
  localparam logic [1:0] MODE_EDGE = 2'b11;
  localparam logic [RW-1:0] EDGE_VAL = RW'((1 << PIXEL_W) - 1);

  logic [PIXEL_W-1:0] w_p [9];
  logic [PW-1:0]      w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic               w_advance;
  logic               w_unused;
  logic [RW-1:0]      w_abs_gx, w_abs_gy, w_mag;
  logic               w_mag_ge_thr;
  logic [RW-1:0]      w_result_next;
  logic               w_edge_hit;

  logic               r_s1_valid;
  logic [PW-1:0]      r_s1_gx_pos, r_s1_gx_neg, r_s1_gy_pos, r_s1_gy_neg;
  logic [1:0]         r_s1_mode;
  logic [RW-1:0]      r_s1_thr;
  logic               r_s2_valid;
  logic [RW-1:0]      r_s2_gx, r_s2_gy;
  logic [1:0]         r_s2_mode;
  logic [RW-1:0]      r_s2_thr;
  logic               r_s3_valid;
  logic [RW-1:0]      r_s3_result;
  logic               r_s3_edge;
  logic [CNT_W-1:0]   r_edge_count;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_p[k] = window_in[k*PIXEL_W +: PIXEL_W];
    end
  end

  // The centre pixel has zero weight in both kernels.
  assign w_unused = ^w_p[4];

  assign w_gx_pos = PW'(w_p[2]) + (PW'(w_p[5]) << 1) + PW'(w_p[8]);
  assign w_gx_neg = PW'(w_p[0]) + (PW'(w_p[3]) << 1) + PW'(w_p[6]);
  assign w_gy_pos = PW'(w_p[6]) + (PW'(w_p[7]) << 1) + PW'(w_p[8]);
  assign w_gy_neg = PW'(w_p[0]) + (PW'(w_p[1]) << 1) + PW'(w_p[2]);

  // Handshake: a word moves on in_valid && in_ready, out on out_valid && out_ready;
  // every stage shifts only when the output slot is empty or being drained.
  assign w_advance = !r_s3_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_abs_gx     = r_s2_gx[RW-1] ? (-r_s2_gx) : r_s2_gx;
  assign w_abs_gy     = r_s2_gy[RW-1] ? (-r_s2_gy) : r_s2_gy;
  assign w_mag        = w_abs_gx + w_abs_gy;
  assign w_mag_ge_thr = (w_mag >= r_s2_thr);
  assign w_edge_hit   = (r_s2_mode == MODE_EDGE) && w_mag_ge_thr;

  always_comb begin
    w_result_next = '0;
    case (r_s2_mode)
      MODE_GX:   w_result_next = r_s2_gx;
      MODE_GY:   w_result_next = r_s2_gy;
      MODE_MAG:  w_result_next = w_mag;
      MODE_EDGE: w_result_next = w_mag_ge_thr ? EDGE_VAL : '0;
      default:   w_result_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_gx_pos <= '0;
      r_s1_gx_neg <= '0;
      r_s1_gy_pos <= '0;
      r_s1_gy_neg <= '0;
      r_s1_mode   <= '0;
      r_s1_thr    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_gx     <= '0;
      r_s2_gy     <= '0;
      r_s2_mode   <= '0;
      r_s2_thr    <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_result <= '0;
      r_s3_edge   <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_gx_pos <= w_gx_pos;
        r_s1_gx_neg <= w_gx_neg;
        r_s1_gy_pos <= w_gy_pos;
        r_s1_gy_neg <= w_gy_neg;
        r_s1_mode   <= mode;
        r_s1_thr    <= threshold;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_gx   <= RW'(r_s1_gx_pos) - RW'(r_s1_gx_neg);
        r_s2_gy   <= RW'(r_s1_gy_pos) - RW'(r_s1_gy_neg);
        r_s2_mode <= r_s1_mode;
        r_s2_thr  <= r_s1_thr;
      end
      r_s3_valid <= r_s2_valid;
      // Result keeps its last value across bubbles.
      if (r_s2_valid) begin
        r_s3_result <= w_result_next;
        r_s3_edge   <= w_edge_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_edge_count <= '0;
    end else if (clear_count) begin
      r_edge_count <= '0;
    end else if (r_s3_valid && out_ready && r_s3_edge && (r_edge_count != '1)) begin
      r_edge_count <= r_edge_count + 1'b1;
    end
  end

  assign out_valid  = r_s3_valid;
  assign result     = r_s3_result;
  assign edge_count = r_edge_count;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Bench for sobel_gradient_pipe: directed scenarios plus randomized streaming
// against an arithmetic reference model and an in-order expected queue.
module tb_sobel_gradient_pipe;

  localparam int PIXEL_W = 8;
  localparam int CNT_W   = 16;
  localparam int RW      = PIXEL_W + 3;
  localparam int WW      = 9 * PIXEL_W;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic             clk;
  logic             n_rst;
  logic [WW-1:0]    window_in;
  logic [1:0]       mode;
  logic [RW-1:0]    threshold;
  logic             in_valid;
  logic             in_ready;
  logic [RW-1:0]    result;
  logic             out_valid;
  logic             out_ready;
  logic             clear_count;
  logic [CNT_W-1:0] edge_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int model_cnt = 0;
  logic [RW-1:0] exp_q[$];
  bit            exp_edge_q[$];

  logic [RW-1:0] mon_exp;
  logic [RW-1:0] mon_new;
  bit            mon_edge;
  bit            mon_new_edge;
  bit            mon_xfer;

  logic [WW-1:0] w029;
  logic [WW-1:0] wmir;
  logic [WW-1:0] wcol;

  sobel_gradient_pipe #(.PIXEL_W(PIXEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .window_in(window_in), .mode(mode),
    .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .clear_count(clear_count), .edge_count(edge_count)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: Sobel kernels applied with integer arithmetic.
  function automatic void ref_model(input logic [WW-1:0] w, input logic [1:0] m,
                                    input logic [RW-1:0] thr,
                                    output logic [RW-1:0] r, output bit e);
    int p[9];
    int gx, gy, mag;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*PIXEL_W +: PIXEL_W]);
    gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    e = (m == 2'b11) && (mag >= int'(thr));
    case (m)
      2'b00:   r = gx[RW-1:0];
      2'b01:   r = gy[RW-1:0];
      2'b10:   r = mag[RW-1:0];
      default: r = e ? RW'((1 << PIXEL_W) - 1) : '0;
    endcase
  endfunction

  function automatic logic [WW-1:0] make_win(input int v[9]);
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PIXEL_W +: PIXEL_W] = PIXEL_W'(v[k]);
    return w;
  endfunction

  function automatic logic [WW-1:0] rand_win();
    logic [WW-1:0] w;
    int sel;
    for (int k = 0; k < 9; k++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      w[k*PIXEL_W +: PIXEL_W] = '0;
      else if (sel == 1) w[k*PIXEL_W +: PIXEL_W] = '1;
      else               w[k*PIXEL_W +: PIXEL_W] = PIXEL_W'($urandom_range(0, 255));
    end
    return w;
  endfunction

  // scoreboard: outputs popped in order, edge counter modelled from transfers
  always @(negedge clk) begin
    if (n_rst) begin
      n_checks++;
      if (edge_count !== CNT_W'(model_cnt)) begin
        n_fail++;
        $display("FAIL sb_edge_count got=%0d exp=%0d t=%0t", edge_count, model_cnt, $time);
      end
      mon_xfer = out_valid && out_ready;
      mon_edge = 1'b0;
      if (mon_xfer) begin
        n_checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_output got=%0d exp=none t=%0t", result, $time);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_edge = exp_edge_q.pop_front();
          if (result !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_result got=%0h exp=%0h t=%0t", result, mon_exp, $time);
          end
        end
      end
      if (in_valid && in_ready) begin
        ref_model(window_in, mode, threshold, mon_new, mon_new_edge);
        exp_q.push_back(mon_new);
        exp_edge_q.push_back(mon_new_edge);
      end
      if (clear_count) model_cnt = 0;
      else if (mon_xfer && mon_edge && model_cnt < MAXC) model_cnt++;
    end
  end

  // driver: present one word and hold it until it is accepted
  task automatic send(input logic [WW-1:0] w, input logic [1:0] m, input logic [RW-1:0] thr);
    int g = 0;
    window_in = w;
    mode      = m;
    threshold = thr;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_accept got=in_ready0 exp=in_ready1 t=%0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (result !== '0) begin n_fail++; $display("FAIL rst_result got=%0h exp=0", result); end
    if (edge_count !== '0) begin n_fail++; $display("FAIL rst_edge_count got=%0d exp=0", edge_count); end
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_latency();
    logic exp_v;
    out_ready = 1'b1;
    send('0, 2'b00, '0);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp_v = (i == 3);
      n_checks++;
      if (out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL latency_valid_c%0d got=%b exp=%b", i, out_valid, exp_v);
      end
    end
    n_checks++;
    if (result !== '0) begin n_fail++; $display("FAIL latency_zero_result got=%0d exp=0", result); end
    drain();
  endtask

  task automatic test_modes();
    logic [RW-1:0] exp_r[3];
    exp_r[0] = 11'd555;
    exp_r[1] = 11'd55;
    exp_r[2] = 11'd610;
    out_ready = 1'b1;
    send(w029, 2'b00, '0);
    send(w029, 2'b01, '0);
    send(w029, 2'b10, '0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL modes_valid_%0d got=%b exp=1", i, out_valid); end
      if (result !== exp_r[i]) begin n_fail++; $display("FAIL modes_result_%0d got=%0d exp=%0d", i, result, exp_r[i]); end
    end
    drain();
  endtask

  task automatic test_mirror();
    int g = 0;
    out_ready = 1'b1;
    send(wmir, 2'b00, '0);
    send(wcol, 2'b10, '0);
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    n_checks++;
    if (result !== 11'h5D5) begin n_fail++; $display("FAIL mirror_gx got=%0h exp=5d5", result); end
    @(negedge clk);
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL column_valid got=%b exp=1", out_valid); end
    if (result !== 11'd1020) begin n_fail++; $display("FAIL column_mag got=%0d exp=1020", result); end
    drain();
  endtask

  task automatic test_edge();
    int g;
    logic [RW-1:0] thr_tab[3];
    logic [RW-1:0] res_tab[3];
    int cnt_tab[3];
    thr_tab = '{11'd600, 11'd611, 11'd610};
    res_tab = '{11'd255, 11'd0, 11'd255};
    cnt_tab = '{1, 1, 2};
    out_ready   = 1'b1;
    clear_count = 1'b1;
    @(posedge clk);
    #1;
    clear_count = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(w029, 2'b11, thr_tab[i]);
      in_valid = 1'b0;
      g = 0;
      @(negedge clk);
      while (!out_valid && g < 20) begin @(negedge clk); g++; end
      n_checks++;
      if (result !== res_tab[i]) begin n_fail++; $display("FAIL edge_result_thr%0d got=%0d exp=%0d", thr_tab[i], result, res_tab[i]); end
      @(posedge clk);
      #1;
      n_checks++;
      if (edge_count !== CNT_W'(cnt_tab[i])) begin n_fail++; $display("FAIL edge_count_thr%0d got=%0d exp=%0d", thr_tab[i], edge_count, cnt_tab[i]); end
    end
    send(w029, 2'b11, '0);
    in_valid    = 1'b0;
    clear_count = 1'b1;
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    n_checks++;
    if (result !== 11'd255) begin n_fail++; $display("FAIL edge_clear_result got=%0d exp=255", result); end
    @(posedge clk);
    #1;
    clear_count = 1'b0;
    n_checks++;
    if (edge_count !== '0) begin n_fail++; $display("FAIL edge_clear_wins got=%0d exp=0", edge_count); end
    drain();
  endtask

  task automatic test_stall();
    int out0;
    logic [RW-1:0] held;
    out0 = n_out;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_win(), 2'($urandom_range(0, 3)), 11'($urandom_range(0, 1200)));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (c == 0) held = result;
          n_checks += 2;
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_c%0d got=%b exp=0", c, in_ready); end
          if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_c%0d got=%b exp=1", c, out_valid); end
          if (c > 0) begin
            n_checks++;
            if (result !== held) begin n_fail++; $display("FAIL stall_result_c%0d got=%0h exp=%0h", c, result, held); end
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_drain got=%0d exp=0", exp_q.size()); end
    if (n_out - out0 != 6) begin n_fail++; $display("FAIL stall_count got=%0d exp=6", n_out - out0); end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(rand_win(), 2'($urandom_range(0, 3)), 11'($urandom_range(0, 1500)));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready   = ($urandom_range(0, 3) != 0);
          clear_count = ($urandom_range(0, 19) == 0);
          @(posedge clk);
          #1;
        end
        clear_count = 1'b0;
        out_ready   = 1'b1;
      end
    join
    drain();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_drain got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    int g = 0;
    out_ready = 1'b1;
    send(w029, 2'b11, '0);
    send(w029, 2'b11, '0);
    send(w029, 2'b11, '0);
    #1;
    n_rst = 1'b0;
    #1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_edge_q.delete();
    model_cnt = 0;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_valid got=%b exp=0", out_valid); end
    if (edge_count !== '0) begin n_fail++; $display("FAIL inflight_edge_count got=%0d exp=0", edge_count); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL inflight_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_stale_c%0d got=%b exp=0", i, out_valid); end
    end
    @(posedge clk);
    #1;
    send(w029, 2'b10, '0);
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    n_checks++;
    if (result !== 11'd610) begin n_fail++; $display("FAIL inflight_first_result got=%0d exp=610", result); end
    drain();
  endtask

  initial begin
    int v029[9] = '{50, 255, 250, 100, 0, 200, 100, 255, 255};
    int vmir[9] = '{250, 255, 50, 200, 0, 100, 255, 255, 100};
    int vcol[9] = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    w029 = make_win(v029);
    wmir = make_win(vmir);
    wcol = make_win(vcol);
    n_rst       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    clear_count = 1'b0;
    window_in   = '0;
    mode        = '0;
    threshold   = '0;
    test_reset();
    test_latency();
    test_modes();
    test_mirror();
    test_edge();
    test_stall();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
